// File: rtl/aes_pkg.sv
// Shared AES types and constants for the byte-serial decryption front end.
// Also provides the byte-lane merge used when assembling a 128-bit state.
package aes_pkg;

    localparam int          AES_BLOCK_BYTES = 16;
    localparam logic [3:0]  AES_LAST_IDX    = 4'd15;

    typedef logic [127:0] aes_state_t;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } state_e;

    // Byte k of a state lives in bits [127-8k -: 8] (FIPS-197 order, byte 0 at the MSB).
    function automatic aes_state_t set_state_byte(input aes_state_t s,
                                                  input logic [3:0] idx,
                                                  input logic [7:0] b);
        aes_state_t r;
        r = s;
        r[7'd127 - {idx, 3'b000} -: 8] = b;
        return r;
    endfunction

endpackage

// File: rtl/aes_inv_shiftrow.sv
// Combinational InvShiftRows: row r of the state is rotated right by r columns.
// Shared with the decryption round datapath.
module aes_inv_shiftrow
    import aes_pkg::*;
(
    input  logic [127:0] dataIn,
    output logic [127:0] dataOut
);

    // out[r][c] = in[r][(c - r) mod 4], with state byte [r][c] = byte r + 4c
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int DST = r + 4 * c;
            localparam int SRC = r + 4 * ((c - r + 4) % 4);
            assign dataOut[127 - 8 * DST -: 8] = dataIn[127 - 8 * SRC -: 8];
        end
    end

endmodule

// File: rtl/aes_inv_shiftrow_deser.sv
// Byte-serial receive stage: assembles 16 ciphertext-state bytes, applies InvShiftRows
// and hands the 128-bit result downstream over a valid/ready handshake.
module aes_inv_shiftrow_deser
    import aes_pkg::*;
#(
    parameter bit RESYNC = 1'b1
)
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   byteIn,
    input  logic         byteValid,
    input  logic         byteFirst,
    output logic         byteReady,
    output logic [127:0] dataOut,
    output logic         outValid,
    input  logic         outReady
);

    state_e      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    aes_state_t  fill_r, fill_s;
    aes_state_t  data_out_r, data_out_s;
    logic        out_valid_r, out_valid_s;
    logic        byte_ready_r;

    logic        accept_s;
    logic        take_s;
    logic        resync_s;
    logic [3:0]  byte_idx_s;
    aes_state_t  merged_s;
    aes_state_t  inv_in_s;
    aes_state_t  inv_out_s;

    assign accept_s   = byteValid & byte_ready_r;
    assign take_s     = out_valid_r & outReady;
    assign resync_s   = accept_s & byteFirst & RESYNC;
    assign byte_idx_s = resync_s ? 4'd0 : cnt_r;
    assign merged_s   = set_state_byte(fill_r, byte_idx_s, byteIn);

    // In STALL the fill register already holds the complete block, byte 15 included.
    assign inv_in_s   = (state_r == STALL) ? fill_r : merged_s;

    aes_inv_shiftrow u_inv (
        .dataIn  (inv_in_s),
        .dataOut (inv_out_s)
    );

    // Next-state, byte counter, fill register and output register update
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        fill_s      = fill_r;
        data_out_s  = data_out_r;
        out_valid_s = out_valid_r & ~take_s;
        case (state_r)
            FILL: begin
                if (accept_s) begin
                    fill_s = merged_s;
                    if (resync_s) begin
                        cnt_s = 4'd1;
                    end else if (cnt_r == AES_LAST_IDX) begin
                        if (!out_valid_r || take_s) begin
                            data_out_s  = inv_out_s;
                            out_valid_s = 1'b1;
                            cnt_s       = 4'd0;
                        end else begin
                            state_s = STALL;
                        end
                    end else begin
                        cnt_s = cnt_r + 4'd1;
                    end
                end else begin
                    fill_s = fill_r;
                end
            end
            STALL: begin
                if (take_s) begin
                    data_out_s  = inv_out_s;
                    out_valid_s = 1'b1;
                    cnt_s       = 4'd0;
                    state_s     = FILL;
                end else begin
                    state_s = STALL;
                end
            end
            default: begin
                state_s = FILL;
                cnt_s   = 4'd0;
            end
        endcase
    end

    // State and datapath registers; byteReady is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= FILL;
            cnt_r        <= 4'd0;
            fill_r       <= '0;
            data_out_r   <= '0;
            out_valid_r  <= 1'b0;
            byte_ready_r <= 1'b1;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            fill_r       <= fill_s;
            data_out_r   <= data_out_s;
            out_valid_r  <= out_valid_s;
            byte_ready_r <= (state_s == FILL);
        end
    end

    assign byteReady = byte_ready_r;
    assign dataOut   = data_out_r;
    assign outValid  = out_valid_r;

endmodule

// File: tb/tb_aes_inv_shiftrow_deser.sv
// Scoreboard bench: random byte streams against a queue-based InvShiftRows model,
// for both RESYNC settings driven by one shared stream.
module tb_aes_inv_shiftrow_deser;

    localparam logic [127:0] BASIC_EXP = 128'h000d0a07_04010e0b_0805020f_0c090603;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   byteIn;
    logic         byteValid, byteFirst, outReady;
    logic         byteReady1, outValid1, byteReady0, outValid0;
    logic [127:0] dataOut1, dataOut0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   blk1[$], blk0[$];
    logic [127:0] exp1[$], exp0[$];
    logic [127:0] e1, e0, hold_d, ref_x;
    logic [7:0]   pre[$];
    bit           hold_v   = 1'b0;
    bit           rand_rdy = 1'b0;
    bit           b2b_active = 1'b0;
    int           b2b_v = 0, b2b_nr = 0;

    always #5 clk = ~clk;

    aes_inv_shiftrow_deser #(.RESYNC(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .byteIn(byteIn), .byteValid(byteValid),
        .byteFirst(byteFirst), .byteReady(byteReady1), .dataOut(dataOut1),
        .outValid(outValid1), .outReady(outReady));

    aes_inv_shiftrow_deser #(.RESYNC(1'b0)) dut_nr (
        .clk(clk), .rst_n(rst_n), .byteIn(byteIn), .byteValid(byteValid),
        .byteFirst(byteFirst), .byteReady(byteReady0), .dataOut(dataOut0),
        .outValid(outValid0), .outReady(outReady));

    function automatic logic [7:0] get_byte(input logic [127:0] x, input int k);
        return x[127 - 8 * k -: 8];
    endfunction

    // Reference InvShiftRows over a list of 16 bytes: out[r][c] = in[r][(c-r) mod 4]
    function automatic logic [127:0] ref_inv(input logic [7:0] q[$]);
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[127 - 8 * (r + 4 * c) -: 8] = q[r + 4 * ((c - r + 4) % 4)];
        return v;
    endfunction

    // Forward ShiftRows: out[r][c] = in[r][(c+r) mod 4]
    function automatic logic [127:0] fwd(input logic [127:0] x);
        logic [127:0] v;
        v = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[127 - 8 * (r + 4 * c) -: 8] = get_byte(x, r + 4 * ((c + r) % 4));
        return v;
    endfunction

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Input monitor: model every accepted byte, push expected blocks
    always @(negedge clk) begin
        if (!rst_n) begin
            blk1.delete(); blk0.delete(); exp1.delete(); exp0.delete();
        end else if (byteValid && byteReady1) begin
            if (byteFirst) blk1.delete();
            blk1.push_back(byteIn);
            if (blk1.size() == 16) begin
                exp1.push_back(ref_inv(blk1));
                blk1.delete();
            end
            blk0.push_back(byteIn);
            if (blk0.size() == 16) begin
                exp0.push_back(ref_inv(blk0));
                blk0.delete();
            end
        end
    end

    // Output monitor: compare each taken block, check hold stability and reset behaviour
    always @(negedge clk) begin
        if (!rst_n) begin
            cmp("valid_in_reset", {127'd0, outValid1}, 128'd0);
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                cmp("hold_valid", {127'd0, outValid1}, 128'd1);
                cmp("hold_data", dataOut1, hold_d);
            end
            if (outValid1 && outReady) begin
                if (exp1.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_block: got %h expected none", dataOut1);
                end else begin
                    e1 = exp1.pop_front();
                    cmp("block_resync1", dataOut1, e1);
                end
            end
            if (outValid0 && outReady) begin
                if (exp0.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_block0: got %h expected none", dataOut0);
                end else begin
                    e0 = exp0.pop_front();
                    cmp("block_resync0", dataOut0, e0);
                end
            end
            hold_v = outValid1 && !outReady;
            hold_d = dataOut1;
        end
    end

    // Back-to-back window counters
    always @(negedge clk) begin
        if (b2b_active) begin
            if (outValid1) b2b_v++;
            if (!byteReady1) b2b_nr++;
        end
    end

    task automatic send(input logic [7:0] b, input logic f);
        int waitc;
        waitc = 0;
        byteIn = b; byteFirst = f; byteValid = 1'b1;
        @(negedge clk);
        while (!byteReady1 && waitc < 200) begin
            @(posedge clk); #1;
            if (rand_rdy) outReady = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            waitc++;
        end
        if (!byteReady1) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: byteReady got 0 expected 1");
        end
        @(posedge clk); #1;
        byteValid = 1'b0; byteFirst = 1'b0;
        if (rand_rdy) outReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; byteIn = 8'd0; byteValid = 1'b0; byteFirst = 1'b0; outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        cmp("reset_valid", {127'd0, outValid1}, 128'd0);
        cmp("reset_data", dataOut1, 128'd0);
        cmp("reset_ready", {127'd0, byteReady1}, 128'd1);
        @(posedge clk); #1;

        // Basic block 00..0f, single-cycle valid pulse
        for (int i = 0; i < 16; i++) send(8'(i), i == 0);
        @(negedge clk);
        cmp("basic_valid", {127'd0, outValid1}, 128'd1);
        cmp("basic_data", dataOut1, BASIC_EXP);
        @(negedge clk);
        cmp("basic_pulse_end", {127'd0, outValid1}, 128'd0);
        @(posedge clk); #1;

        // Backpressure: two blocks with the output blocked
        outReady = 1'b0;
        for (int i = 0; i < 32; i++) send(8'($urandom), (i % 16) == 0);
        @(negedge clk);
        cmp("stall_ready", {127'd0, byteReady1}, 128'd0);
        cmp("stall_valid", {127'd0, outValid1}, 128'd1);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 outReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmp("second_valid", {127'd0, outValid1}, 128'd1);
        cmp("ready_back", {127'd0, byteReady1}, 128'd1);
        @(posedge clk); #1;

        // Back-to-back stream
        b2b_active = 1'b1;
        for (int i = 0; i < 64; i++) send(8'($urandom), 1'b0);
        @(negedge clk);
        #1 b2b_active = 1'b0;
        cmp("b2b_valid_count", 128'(b2b_v), 128'd4);
        cmp("b2b_ready_drops", 128'(b2b_nr), 128'd0);
        @(posedge clk); #1;

        // Round check: forward ShiftRows of random states, random output stalls
        rand_rdy = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            ref_x = {$urandom, $urandom, $urandom, $urandom};
            ref_x = fwd(ref_x);
            for (int k = 0; k < 16; k++)
                send(get_byte(ref_x, k), (k == 0) && ($urandom_range(0, 1) == 1));
        end
        rand_rdy = 1'b0; outReady = 1'b1;
        idle(4);

        // Resync: 5 stray bytes then a flagged block 00..0f
        pre.delete();
        for (int i = 0; i < 5; i++) begin
            pre.push_back(8'($urandom));
            send(pre[i], i == 0);
        end
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i == 0);
            if (i == 10) begin
                for (int j = 0; j <= 10; j++) pre.push_back(8'(j));
                @(negedge clk);
                cmp("noresync_data", dataOut0, ref_inv(pre));
                cmp("noresync_valid", {127'd0, outValid0}, 128'd1);
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        cmp("resync_data", dataOut1, BASIC_EXP);
        @(posedge clk); #1;

        // Reset mid-block
        for (int i = 0; i < 9; i++) send(8'($urandom), i == 0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b0);
        @(negedge clk);
        cmp("post_reset_valid", {127'd0, outValid1}, 128'd1);
        cmp("post_reset_data", dataOut1, BASIC_EXP);
        cmp("post_reset_data0", dataOut0, BASIC_EXP);
        @(posedge clk); #1;

        idle(4);
        cmp("sb_empty1", 128'(exp1.size()), 128'd0);
        cmp("sb_empty0", 128'(exp0.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_inv_shiftrow_deser.md
# aes_inv_shiftrow_deser

Byte-serial input stage for the AES decryption datapath. Collects 16 ciphertext-state bytes from an 8-bit valid/ready stream, applies InvShiftRows (the inverse of the existing forward ShiftRows block), and presents the result as a 128-bit state on a valid/ready output. It is the receive-side counterpart of the 128-bit forward ShiftRows path. It feeds the decryption round pipeline, which starts with InvSubBytes.

## Interface
Parameters:
- RESYNC, 1: when 1, `byteFirst` restarts block assembly; when 0, `byteFirst` is ignored.

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- byteIn  in  8  state byte, FIPS-197 order (byte k = in[r+4c])
- byteValid  in  1  byteIn is valid
- byteFirst  in  1  marks byte 0 of a block; qualified by byteValid
- byteReady  out  1  block accepts a byte this cycle
- dataOut  out  128  InvShiftRows(state); byte 0 is in [127:120]
- outValid  out  1  dataOut holds a complete block
- outReady  in  1  downstream accepts dataOut

## Operation
- A byte is accepted when `byteValid && byteReady`. An output block is taken when `outValid && outReady`.
- The fill register `fillReg[127:0]` and the 4-bit counter `cnt` hold the block being assembled. An accepted byte is written to bits [127-8*cnt -: 8].
- FSM states:
  - FILL: `byteReady=1`.
  - STALL: a full block is waiting and the output register is occupied; `byteReady=0`.
- When a byte is accepted with `cnt==15`, the block is complete:
  - If `!outValid` or the output is taken in the same cycle: `dataOut <= inv(fillReg with the last byte merged)`, `outValid <= 1`, `cnt <= 0`, state stays FILL.
  - Otherwise: state goes to STALL and `cnt` holds at 15.
- In STALL, when the output is taken: move the fill block to `dataOut`, keep `outValid=1`, set `cnt=0`, go to FILL.
- InvShiftRows: `out[r][c] = in[r][(c-r) mod 4]`, where state byte [r][c] = byte r+4c.
- If the output is taken and no new block is completing in that cycle, `outValid <= 0`.
- RESYNC=1 and a byte is accepted with `byteFirst=1`: the byte is stored as byte 0 and `cnt <= 1`, regardless of the current `cnt`. Any partial block is discarded, and the output register is unaffected.
- When `byteFirst=0` at `cnt==0`, the byte is still accepted as byte 0; no error is raised.
- Reset values: `cnt=0`, state FILL, `outValid=0`, `dataOut=0`, `fillReg=0`, `byteReady=1` once reset is released.

## Timing
- Latency: `outValid` rises on the edge that accepts byte 15, so it is visible the cycle after that acceptance.
- Throughput: one block per 16 byte-accept cycles with zero bubbles, as long as `outReady` is held high.
- `byteReady` is decoded from state only; there is no combinational path from `outReady` to `byteReady`.
- `dataOut` and `outValid` are held stable while `outValid && !outReady`.
- If the output is taken in the same cycle that byte 15 is accepted, the new block replaces the old one with no gap cycle.
- Asserting `rst_n` low at any point, including mid-block or in STALL, immediately clears all state; partial data is lost.

## Structure
- aes_pkg holds `AES_BLOCK_BYTES=16`, the `aes_state_t` typedef (logic [127:0]), and the `state_e` enum {FILL, STALL}.
- Sub-module aes_inv_shiftrow is combinational: `dataIn[127:0]` to `dataOut[127:0]`. It is also reused by the decryption round and verified standalone against forward ShiftRows (`inv(fwd(x)) == x`).

## Test plan
- Basic block: feed bytes 00..0f with `outReady=1` -> `outValid` pulses for one cycle after byte 0f, and `dataOut = 128'h000d0a07_04010e0b_0805020f_0c090603`.
- FIPS-197 round check: feed the forward ShiftRows output of random states (1000 vectors) -> `dataOut` equals the original state for every vector.
- Backpressure: `outReady=0`, feed 32 bytes -> after the second block `byteReady=0` and the FSM is in STALL; the first block is held stable. Raise `outReady` -> the first block is taken, the second block appears on the next cycle, and `byteReady` returns to 1.
- Back-to-back: continuous bytes with `outReady=1` -> `outValid` is high once every 16 cycles and `byteReady` never drops.
- Resync: 5 bytes, then `byteFirst` with 00..0f -> output matches the basic-block vector; with RESYNC=0 the output instead reflects the first 16 bytes.
- Reset mid-block: pull `rst_n` low after 9 bytes, release it, then feed 16 bytes -> `outValid` is low throughout the reset, and the output after release matches the new 16 bytes only.
